// File: rtl/pinky_pkg.sv
// pinky_pkg: shared PinKY word layout, field ranges, opcode and condition-code constants.
package pinky_pkg;
  localparam int WORD = 16;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int CC_HI = 10;
  localparam int CC_LO = 9;
  localparam int DEST_HI = 8;
  localparam int DEST_LO = 5;
  localparam int OP2_HI = 3;
  localparam int OP2_LO = 0;
  localparam logic [4:0] OPSYS = 5'h13;
  localparam logic [4:0] OPNOP = 5'h14;
  typedef enum logic [1:0] {AL = 2'd0, S = 2'd1, EQ = 2'd2, NE = 2'd3} cc_e;
  typedef struct packed {
    logic [WORD-1:0] pc;
    logic [WORD-1:0] ir;
  } fetch_entry_t;
  function automatic logic squash_f(input logic [WORD-1:0] w, input logic z);
    return (w[CC_HI:CC_LO] == EQ && !z) || (w[CC_HI:CC_LO] == NE && z);
  endfunction
endpackage

// File: rtl/pinky_fetch_unit_if.sv
// pinky_fetch_unit_if: imem, writeback and decode signals of the fetch unit.
interface pinky_fetch_unit_if;
  import pinky_pkg::*;
  logic imem_req;
  logic [WORD-1:0] imem_addr;
  logic imem_ack;
  logic [WORD-1:0] imem_data;
  logic redirect;
  logic [WORD-1:0] redirect_pc;
  logic z;
  logic [WORD-1:0] ir;
  logic [WORD-1:0] pc;
  logic ir_valid;
  logic ir_ready;
  logic halt;
  modport master (
    output imem_req, imem_addr, ir, pc, ir_valid, halt,
    input imem_ack, imem_data, redirect, redirect_pc, z, ir_ready
  );
  modport slave (
    input imem_req, imem_addr, ir, pc, ir_valid, halt,
    output imem_ack, imem_data, redirect, redirect_pc, z, ir_ready
  );
endinterface

// File: rtl/pinky_fetch_fifo.sv
// pinky_fetch_fifo: synchronous prefetch FIFO with flush; head is visible one cycle after push.
module pinky_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    full = count_q == (AW+1)'(DEPTH);
    empty = count_q == '0;
    count = count_q;
    head = mem_q[rd_ptr_q];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/pinky_fetch_unit.sv
// pinky_fetch_unit: PinKY fetch front end with prefetch FIFO, CC squash, redirect and SYS halt.
module pinky_fetch_unit
  import pinky_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input logic              clk,
  input logic              reset,
  pinky_fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_entry_t head;
  logic full, empty, xfer, pop, flush;
  logic [CW-1:0] count;
  logic [WORD-1:0] fetch_pc_q, fetch_pc_d, ir_eff;
  logic halt_q, halt_d;
  pinky_fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_fifo (
    .clk(clk), .reset(reset), .push(xfer), .pop(pop), .flush(flush),
    .din({fetch_pc_q, bus.imem_data}), .full(full), .empty(empty), .count(count), .head(head)
  );
  // reset level gates the handshakes so an ack or a full FIFO is ignored while reset is held
  always_comb begin
    bus.imem_req = reset && !halt_q && !bus.redirect && !full;
    bus.imem_addr = fetch_pc_q;
    xfer = bus.imem_req && bus.imem_ack;
    ir_eff = squash_f(head.ir, bus.z) ? {OPNOP, 11'h000} : head.ir;
    bus.ir_valid = reset && !empty && !halt_q && !bus.redirect;
    bus.ir = bus.ir_valid ? ir_eff : '0;
    bus.pc = bus.ir_valid ? head.pc : '0;
    bus.halt = halt_q;
    pop = bus.ir_valid && bus.ir_ready;
    flush = bus.redirect && !halt_q;
    fetch_pc_d = bus.redirect ? bus.redirect_pc : xfer ? fetch_pc_q + WORD'(1) : fetch_pc_q;
    halt_d = halt_q || (pop && ir_eff[OPC_HI:OPC_LO] == OPSYS);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      halt_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      halt_q <= halt_d;
    end
  end
  assert property (@(posedge clk) full == (count == CW'(DEPTH)));
endmodule

// File: tb/tb_pinky_fetch_unit.sv
// tb_pinky_fetch_unit: queue-based reference model and scoreboard for the fetch unit.
module tb_pinky_fetch_unit;
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] w;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] mem [256];
  ent_t exp_q[$];
  logic [15:0] m_pc = 16'h0;
  bit m_halt = 1'b0;
  bit m_sys = 1'b0;
  bit m_req = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  pinky_fetch_unit_if bus();
  pinky_fetch_unit #(.DEPTH(4), .RESET_PC(16'h0)) dut (.clk(clk), .reset(reset), .bus(bus));
  assign bus.imem_data = mem[bus.imem_addr[7:0]];
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  // monitor: compare everything the DUT presents, pop the scoreboard on each accepted instruction
  initial forever begin
    logic exp_valid, sq;
    logic [15:0] e_ir, e_pc, w;
    @(negedge clk);
    #1;
    exp_valid = reset && exp_q.size() > 0 && !m_halt && !bus.redirect;
    m_req = reset && !m_halt && !bus.redirect && exp_q.size() < 4;
    chk("imem_req", bus.imem_req, m_req);
    if (m_req) chk("imem_addr", bus.imem_addr, m_pc);
    chk("ir_valid", bus.ir_valid, exp_valid);
    chk("halt", bus.halt, m_halt);
    e_ir = 16'h0;
    e_pc = 16'h0;
    if (exp_valid) begin
      w = exp_q[0].w;
      sq = (w[10:9] == 2'd2 && !bus.z) || (w[10:9] == 2'd3 && bus.z);
      e_ir = sq ? 16'hA000 : w;
      e_pc = exp_q[0].pc;
    end
    chk("ir", bus.ir, e_ir);
    chk("pc", bus.pc, e_pc);
    if (exp_valid && bus.ir_ready) begin
      void'(exp_q.pop_front());
      if (e_ir[15:11] == 5'h13) m_sys = 1'b1;
    end
  end
  // reference model: every accepted fetch pushes the expected {pc,word}
  always @(posedge clk) begin
    if (!reset) begin
      exp_q.delete();
      m_pc = 16'h0;
      m_halt = 1'b0;
      m_sys = 1'b0;
    end else begin
      if (bus.redirect) begin
        if (!m_halt) exp_q.delete();
        m_pc = bus.redirect_pc;
      end else if (m_req && bus.imem_ack) begin
        exp_q.push_back(ent_t'({m_pc, mem[m_pc[7:0]]}));
        m_pc = m_pc + 16'h1;
      end
      if (m_sys) m_halt = 1'b1;
      m_sys = 1'b0;
    end
  end
  task automatic step(input bit ack, input bit rdy, input bit zz, input bit rd, input logic [15:0] rpc);
    @(negedge clk);
    reset = 1'b1;
    bus.imem_ack = ack;
    bus.ir_ready = rdy;
    bus.z = zz;
    bus.redirect = rd;
    bus.redirect_pc = rpc;
  endtask
  task automatic rst_cycle(input bit ack);
    @(negedge clk);
    reset = 1'b0;
    bus.imem_ack = ack;
    bus.ir_ready = 1'b1;
    bus.redirect = 1'b0;
  endtask
  initial begin
    logic [15:0] w;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:11] == 5'h13) w[15:11] = 5'h0;
      mem[i] = w;
    end
    mem[0] = 16'h0000;
    mem[1] = 16'h1234;
    mem[2] = 16'h0410;
    mem[3] = 16'h0600;
    bus.imem_ack = 1'b0;
    bus.ir_ready = 1'b0;
    bus.z = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 16'h0;
    rst_cycle(1'b0);
    rst_cycle(1'b1);
    repeat (20) step(1, 1, 0, 0, 16'h0);
    rst_cycle(1'b1);
    repeat (10) step(1, 0, 0, 0, 16'h0);
    repeat (12) step(1, 1, 0, 0, 16'h0);
    step(1, 1, 1, 1, 16'h0002);
    repeat (6) step(1, 1, 1, 0, 16'h0);
    step(1, 1, 0, 1, 16'h0002);
    repeat (6) step(1, 1, 1'($urandom), 0, 16'h0);
    repeat (400) step(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(15) == 0), 16'($urandom_range(255)));
    repeat (3) step(1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 1, 16'h0040);
    repeat (8) step(1, 1, 0, 0, 16'h0);
    step(1, 1, 0, 1, 16'hFFFE);
    repeat (8) step(1, 1, 0, 0, 16'h0);
    repeat (6) step(1, 0, 0, 0, 16'h0);
    rst_cycle(1'b1);
    repeat (6) step(1, 1, 0, 0, 16'h0);
    rst_cycle(1'b1);
    mem[4] = 16'h9E00;
    mem[5] = 16'h9800;
    repeat (12) step(1, 1, 1, 0, 16'h0);
    step(1, 1, 1, 1, 16'h0080);
    repeat (4) step(1, 1, 0, 0, 16'h0);
    rst_cycle(1'b1);
    repeat (4) step(1, 1, 0, 0, 16'h0);
    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
